if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction fetch unit driving the IF side of the IF/ID pipeline register. It owns the program counter and issues single-outstanding requests to instruction memory. Each returned word is buffered and presented as a (pc, pc+4, instr) triple with a write-enable. The block also generates the IF/ID flush when the EX stage redirects control flow.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset release
- i_clk  in  1  clock, rising edge
- i_resetn  in  1  reset, asynchronous, active-low
- i_stall  in  1  hazard stall; IF/ID must not be written
- i_redirect  in  1  taken branch/jump resolved in EX
- i_redirect_pc  in  32  redirect target
- o_imem_req  out  1  fetch request valid
- o_imem_addr  out  32  fetch address
- i_imem_gnt  in  1  request accepted this cycle (meaningful only while o_imem_req=1)
- i_imem_rvalid  in  1  response valid; at most one per accepted request, ≥1 cycle after gnt
- i_imem_rdata  in  32  instruction word
- o_if_pc  out  32  buffered instruction address
- o_if_p4  out  32  o_if_pc + 4
- o_if_instr  out  32  buffered instruction
- o_ifid_we  out  1  write enable to IF/ID
- o_ifid_flush  out  1  flush to IF/ID (inserts NOP)
- o_fetch_misalign  out  1  misaligned redirect pulse (see Configuration)

## Operation
- Registers: pc, state, buffer (o_if_pc, o_if_p4, o_if_instr).
- States: BOOT, REQ, WAIT, VALID, DROP.
- BOOT: reset state; o_imem_req=0; next cycle -> REQ.
- REQ: o_imem_req=1, o_imem_addr=pc; gnt -> WAIT, else stay.
- WAIT: on rvalid, buffer <= {pc, pc+4, rdata}, pc <= pc+4, -> VALID.
- VALID: o_ifid_we = ~i_stall.
  - Not stalled: o_imem_req=1 with addr=pc; gnt -> WAIT, else -> REQ.
  - Stalled: buffer held, no request, stay VALID.
- Redirect has top priority, overriding stall in any state except BOOT:
  - o_ifid_flush = i_redirect, combinational.
  - o_ifid_we=0 and o_imem_req=0 in that cycle.
  - pc <= aligned i_redirect_pc.
  - REQ/VALID -> REQ.
  - WAIT: -> REQ if rvalid in the same cycle (word discarded), else -> DROP.
  - DROP: stays DROP.
- DROP: o_imem_req=0; rvalid discards the word -> REQ.
- Arithmetic: pc+4 is 32-bit modulo; 0xFFFF_FFFC wraps to 0x0000_0000.
- Buffer is written only on an accepted response, never on stall.

## Timing
- Reset values:
  - pc=RESET_PC, state=BOOT.
  - o_if_pc=0, o_if_p4=0, o_if_instr=32'h0000_0013.
  - o_imem_req=0, o_ifid_we=0, o_ifid_flush=0, o_fetch_misalign=0.
- Reset mid-operation: immediate return to BOOT; any in-flight response after release is ignored in BOOT and REQ.
- Latency: with gnt on the request cycle and rvalid 1 cycle later, o_ifid_we rises 2 cycles after the request cycle.
- Peak throughput: 1 instruction per 2 cycles.
- o_ifid_we, o_ifid_flush, o_imem_req, o_imem_addr are combinational from state/inputs. All other outputs are registered.
- Redirect takes effect on the next fetch: first request to the new pc is in the cycle after the redirect.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - Redirect with i_redirect_pc[1:0]≠0 pulses o_fetch_misalign for exactly one cycle, registered, the cycle after the redirect.
  - pc <= {i_redirect_pc[31:2],2'b00}.
- Undefined: low bits are forced to 00 silently; o_fetch_misalign tied 0.

## Test plan
- Release reset, RESET_PC=0x100, zero-wait memory returning 0xAAAA0001 -> first o_ifid_we with o_if_pc=0x100, o_if_p4=0x104, o_if_instr=0xAAAA0001; next request addr=0x104.
- i_stall held 3 cycles in VALID -> o_ifid_we=0, buffer unchanged, no o_imem_req; fetch resumes the cycle stall drops.
- Redirect to 0x200 while in WAIT, rvalid 2 cycles later with 0xDEAD0000 -> o_ifid_flush high 1 cycle, 0xDEAD0000 never presented, next request addr=0x200.
- Redirect coincident with i_stall in VALID -> flush=1, we=0, next request 0x200.
- pc=0xFFFF_FFFC fetch -> o_if_p4=0x0000_0000, next request addr=0x0.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x302 -> o_fetch_misalign pulses once, request addr=0x300; without the macro -> addr=0x300, no pulse.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: program counter owner and single-outstanding instruction
// fetcher feeding the IF/ID register, with EX-redirect flush generation.
//
// Ports:
//   i_clk, i_resetn          clock, async active-low reset
//   i_stall                  hazard stall (hold IF/ID, no new request)
//   i_redirect, i_redirect_pc  EX-resolved control-flow change
//   o_imem_req/addr, i_imem_gnt, i_imem_rvalid/rdata  imem handshake
//   o_if_pc/p4/instr         buffered fetch triple
//   o_ifid_we, o_ifid_flush  IF/ID write enable and flush
//   o_fetch_misalign         pulse on misaligned redirect
//
// Build option: define FETCH_ALIGN_CHECK_EN to enable o_fetch_misalign;
// otherwise low redirect bits are dropped silently and the pulse is tied 0.

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_p4,
  output logic [31:0] o_if_instr,
  output logic        o_ifid_we,
  output logic        o_ifid_flush,
  output logic        o_fetch_misalign
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic [31:0] pc_p4;
  logic [31:0] redir_pc;
  logic        redir;
  logic        buf_we;
  logic        st_boot;
  logic        st_req;
  logic        st_wait;
  logic        st_valid;
  logic        st_drop;

  assign st_boot  = (state == S_BOOT);
  assign st_req   = (state == S_REQ);
  assign st_wait  = (state == S_WAIT);
  assign st_valid = (state == S_VALID);
  assign st_drop  = (state == S_DROP);

  // Redirect is ignored in BOOT so it cannot
  // disturb the first fetch after reset.
  assign redir    = i_redirect && !st_boot;
  assign redir_pc = i_redirect_pc & 32'hFFFF_FFFC;
  assign pc_p4    = pc + 32'd4;

  assign o_imem_addr  = pc;
  assign o_ifid_flush = redir;
  assign o_ifid_we    = !redir && st_valid
                        && !i_stall;
  assign o_imem_req   = !redir
                        && (st_req
                            || (st_valid
                                && !i_stall));

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    buf_we   = 1'b0;
    if (redir) begin
      pc_nx = redir_pc;
      // A response still owed by memory must
      // be swallowed before fetching again.
      if ((st_wait || st_drop)
          && !i_imem_rvalid)
        state_nx = S_DROP;
      else
        state_nx = S_REQ;
    end else begin
      unique case (1'b1)
        st_boot: state_nx = S_REQ;
        st_req: begin
          if (i_imem_gnt)
            state_nx = S_WAIT;
        end
        st_wait: begin
          if (i_imem_rvalid) begin
            buf_we   = 1'b1;
            pc_nx    = pc_p4;
            state_nx = S_VALID;
          end
        end
        st_valid: begin
          if (!i_stall)
            state_nx = i_imem_gnt ? S_WAIT
                                  : S_REQ;
        end
        st_drop: begin
          if (i_imem_rvalid)
            state_nx = S_REQ;
        end
        default: state_nx = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state <= S_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_if_pc    <= 32'h0;
      o_if_p4    <= 32'h0;
      o_if_instr <= NOP;
    end else if (buf_we) begin
      o_if_pc    <= pc;
      o_if_p4    <= pc_p4;
      o_if_instr <= i_imem_rdata;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn)
      mis_q <= 1'b0;
    else
      mis_q <= redir
               && (i_redirect_pc[1:0] != 2'b00);
  end

  assign o_fetch_misalign = mis_q;
`else
  assign o_fetch_misalign = 1'b0;
`endif

endmodule
